// File: rtl/multi_port_stream_serializer_pkg.sv
// Shared helpers for the multi-port stream serializer: index-width sizing only.
package multi_port_stream_serializer_pkg;

    // Narrowest index register we allow, even for a single-lane build.
    localparam int MinIdxWidth = 1;

    // Bits needed to address n lanes, never less than MinIdxWidth.
    function automatic int idx_width(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : MinIdxWidth;
        return (w < MinIdxWidth) ? MinIdxWidth : w;
    endfunction

endpackage

// File: rtl/multi_port_stream_serializer_find_first_one_idx.sv
// Lowest-set-bit finder. With above_only set, bits at or below base are
// ignored so the same block can both pick the first lane of a new group
// and advance past the lane that was just emitted.
module find_first_one_idx
    import multi_port_stream_serializer_pkg::*;
#(
    parameter int Width = 2,
    parameter int IdxW  = idx_width(Width)
) (
    input  logic [Width-1:0] vec,
    input  logic [IdxW-1:0]  base,
    input  logic             above_only,
    output logic [IdxW-1:0]  idx,
    output logic             found
);

    // Scan from the top down so the lowest qualifying bit is the one that sticks.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (vec[i] && (!above_only || (i > int'(base)))) begin
                idx   = IdxW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_port_stream_serializer.sv
// Accepts a whole group of parallel lanes in one cycle and replays the valid
// lanes one beat per cycle in ascending lane order. The next group reloads on
// the same edge the final beat leaves, so back-to-back groups have no bubble.
module multi_port_stream_serializer
    import multi_port_stream_serializer_pkg::*;
#(
    parameter int InWidth   = 2,
    parameter int DataWidth = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [InWidth-1:0]                in_vld_i,
    input  logic [InWidth-1:0][DataWidth-1:0] in_payload_i,
    output logic [InWidth-1:0]                in_rdy_o,
    output logic                              out_vld_o,
    output logic [DataWidth-1:0]              out_payload_o,
    input  logic                              out_rdy_i,
    input  logic                              flush_i
);

    localparam int IdxW = idx_width(InWidth);

    logic [DataWidth-1:0] buf_q [InWidth];
    logic [InWidth-1:0]   bvld;
    logic [IdxW-1:0]      ridx;

    logic            out_fire;
    logic            single_left;
    logic            last_fire;
    logic            load_ok;
    logic            in_fire;
    logic [IdxW-1:0] first_idx;
    logic            first_found;
    logic [IdxW-1:0] next_idx;
    logic            next_found;

    // Lane to emit first when a new group is captured.
    find_first_one_idx #(.Width(InWidth), .IdxW(IdxW)) u_first (
        .vec        (in_vld_i),
        .base       ('0),
        .above_only (1'b0),
        .idx        (first_idx),
        .found      (first_found)
    );

    // Next lane still pending above the one currently on the output.
    find_first_one_idx #(.Width(InWidth), .IdxW(IdxW)) u_next (
        .vec        (bvld),
        .base       (ridx),
        .above_only (1'b1),
        .idx        (next_idx),
        .found      (next_found)
    );

    assign out_vld_o     = bvld[ridx];
    assign out_payload_o = buf_q[ridx];
    assign out_fire      = out_vld_o & out_rdy_i;
    assign single_left   = (bvld != '0) && ((bvld & (bvld - InWidth'(1))) == '0);
    assign last_fire     = out_fire & single_left;
    assign load_ok       = (bvld == '0) | last_fire;
    assign in_rdy_o      = {InWidth{load_ok & ~flush_i}};
    // An all-zero valid vector finds nothing, so an empty group never fires.
    assign in_fire       = load_ok & ~flush_i & first_found;

    // Payload storage: one enabled register per lane, deliberately not reset.
    for (genvar g = 0; g < InWidth; g++) begin : g_buf
        always_ff @(posedge clk) begin
            if (in_fire) begin
                buf_q[g] <= in_payload_i[g];
            end
        end
    end

    // Pending-lane mask and read pointer: flush beats load, load beats drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvld <= '0;
            ridx <= '0;
        end else if (flush_i) begin
            bvld <= '0;
        end else if (in_fire) begin
            bvld <= in_vld_i;
            ridx <= first_idx;
        end else if (out_fire) begin
            bvld[ridx] <= 1'b0;
            if (next_found) begin
                ridx <= next_idx;
            end
        end
    end

endmodule

// File: doc/multi_port_stream_serializer.md
MULTI_PORT_STREAM_SERIALIZER -- requirements
Module: multi_port_stream_serializer

Interface
REQ-001 SHALL have parameter InWidth, default 2, meaning number of input lanes (2..8).
REQ-002 SHALL have parameter DataWidth, default 32, meaning payload bits per lane.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_vld_i  input  InWidth  per-lane valid; lane 0 is the oldest entry.
REQ-006 SHALL have port in_payload_i  input  InWidth x DataWidth  per-lane payload.
REQ-007 SHALL have port in_rdy_o  output  InWidth  per-lane ready; all bits are always equal.
REQ-008 SHALL have port out_vld_o  output  1  output valid.
REQ-009 SHALL have port out_payload_o  output  DataWidth  output payload.
REQ-010 SHALL have port out_rdy_i  input  1  output ready.
REQ-011 SHALL have port flush_i  input  1  synchronous discard of all held entries.

Function
REQ-012 SHALL hold the following state.
- Buffer buf: InWidth entries of DataWidth bits.
- Valid mask bvld: InWidth bits.
- Read index ridx: $clog2(InWidth) bits, minimum 1.
REQ-013 SHALL fire an input lane i when in_vld_i[i] & in_rdy_o[i], and SHALL fire the output when out_vld_o & out_rdy_i.
REQ-014 SHALL define last_fire = output fire while bvld has exactly one bit set.
REQ-015 SHALL define load_ok = (bvld == 0) | last_fire.
REQ-016 SHALL drive in_rdy_o = {InWidth{load_ok & ~flush_i}}; the whole group is accepted in one cycle or not at all.
REQ-017 SHALL, on any input fire, load the group on that edge.
- buf[i] <= in_payload_i[i] and bvld[i] <= in_vld_i[i], for every lane i.
- ridx <= index of the lowest set bit of in_vld_i; lanes with in_vld_i low are skipped.
REQ-018 SHALL drive out_vld_o = bvld[ridx] and out_payload_o = buf[ridx], directly from registers with no combinational path from any input.
REQ-019 SHALL, on an output fire that is not last_fire, clear bvld[ridx] and move ridx to the lowest set bit of the remaining mask above ridx.
REQ-020 SHALL emit the lanes of a group strictly in ascending lane order.
- Latency: first beat appears 1 cycle after input fire.
- Throughput: 1 beat per cycle, including back-to-back groups, because of the reload on last_fire.
REQ-021 SHALL keep buf, bvld and ridx unchanged while out_rdy_i is low (stall); out_payload_o SHALL stay stable while out_vld_o is high.
REQ-022 SHALL, when flush_i is high, clear bvld on that edge, ignore the output fire, and load nothing; this has priority over every other update.
REQ-023 SHALL NOT fire any input lane when in_vld_i is all-zero.
REQ-024 SHALL reach the final beat and set load_ok for a group of exactly one valid lane, with no idle cycle after it.

Reset
REQ-025 SHALL, while rst is high, asynchronously force bvld = 0 and ridx = 0, giving out_vld_o = 0 and in_rdy_o = all-ones once rst is low and flush_i is low.
REQ-026 SHALL NOT reset buf; out_payload_o is don't-care while out_vld_o = 0.
REQ-027 SHALL discard any partially drained group when rst asserts mid-operation; no beat of that group appears after rst deasserts.

Structure
REQ-028 SHALL use no new shared-package typedefs; widths derive from parameters only.
REQ-029 SHALL implement the lowest-set-bit search (masked above ridx) as one sub-module, find_first_one_idx, parameterised by width, returning index and a found flag.
REQ-030 SHALL place one register per buf entry with an enable taken from the load condition, and SHALL use a resettable register for bvld and ridx.

Verification
REQ-031 Reset, then idle: out_vld_o = 0 and in_rdy_o = 2'b11 from the first cycle after rst deasserts.
REQ-032 Group {A,B}, both valid, out_rdy_i = 1: A at cycle +1, B at +2; a second group {C,D} offered at +2 is accepted, giving C at +3 and D at +4 with no bubble.
REQ-033 Group with in_vld_i = 2'b10, payload B in lane 1: a single beat B at +1; lane 0 is never emitted.
REQ-034 {A,B} loaded, out_rdy_i held low for 3 cycles: A stable on out_payload_o, in_rdy_o = 0 throughout; then out_rdy_i = 1 gives A, B in order.
REQ-035 {A,B} loaded, A fired, flush_i pulsed with out_rdy_i = 1: B is never emitted, out_vld_o = 0 next cycle, in_rdy_o = 0 during the flush cycle and 1 after.
REQ-036 InWidth = 4, in_vld_i = 4'b1011 with payloads 0x10, 0x11, 0x12, 0x13 on lanes 0..3: output sequence is 0x10, 0x11, 0x13.
